// File: rtl/uart_boot_loader.sv
// UART boot loader: parses magic/length/data/checksum frames from the RX byte
// stream, writes words into RAM and releases the CPU reset after a good load.
module uart_boot_loader #(
  parameter logic [29:0] BaseAddr      = 30'h0,
  parameter int unsigned MaxWords      = 16384,
  parameter int unsigned TimeoutCycles = 1_000_000,
  parameter logic [7:0]  Magic         = 8'hB0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [29:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  output logic        ram_wr_o,
  output logic [3:0]  ram_byte_en_o,
  output logic        cpu_rst_n_o,
  output logic        busy_o,
  output logic        error_o
);

  localparam int GW = $clog2(TimeoutCycles + 1);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE} state_e;

  state_e        state, state_nxt;
  logic [1:0]    byte_cnt;
  logic [31:0]   shreg, len;
  logic [29:0]   idx;
  logic [7:0]    csum;
  logic [GW-1:0] gap;
  logic          err_q, cpu_rst_q;
  logic          accept, in_rx, timeout, last_byte, last_word;
  logic [31:0]   asm_word;

  // Bytes shift in from the top so the first byte ends up in bits [7:0].
  assign asm_word  = {rx_data_i, shreg[31:8]};
  assign accept    = rx_valid_i & rx_ready_o;
  assign in_rx     = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
  assign timeout   = in_rx && (gap == GW'(TimeoutCycles));
  assign last_byte = (byte_cnt == 2'd3);
  assign last_word = ((32'(idx) + 32'd1) == len);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept && rx_data_i == Magic) state_nxt = S_LEN;
      S_LEN: begin
        if (timeout) state_nxt = S_IDLE;
        else if (accept && last_byte) begin
          if (asm_word > 32'(MaxWords)) state_nxt = S_IDLE;
          else if (asm_word == 32'd0)   state_nxt = S_CSUM;
          else                          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (timeout)                 state_nxt = S_IDLE;
        else if (accept && last_byte) state_nxt = S_WRITE;
      end
      S_WRITE: state_nxt = last_word ? S_CSUM : S_DATA;
      S_CSUM: begin
        if (timeout)     state_nxt = S_IDLE;
        else if (accept) state_nxt = (rx_data_i == csum) ? S_DONE : S_IDLE;
      end
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt    <= '0;
      shreg       <= '0;
      len         <= '0;
      idx         <= '0;
      csum        <= '0;
      gap         <= '0;
      err_q       <= 1'b0;
      cpu_rst_q   <= 1'b0;
      ram_addr_o  <= '0;
      ram_wdata_o <= '0;
    end else begin
      if (!in_rx || accept)  gap <= '0;
      else if (!timeout)     gap <= gap + GW'(1);

      // Every fall back to IDLE from inside a frame is an abort.
      if (state != S_IDLE && state_nxt == S_IDLE) err_q <= 1'b1;

      case (state)
        S_IDLE: if (accept && rx_data_i == Magic) begin
          byte_cnt <= '0;
          csum     <= '0;
          idx      <= '0;
          err_q    <= 1'b0;
        end
        S_LEN: if (accept && !timeout) begin
          shreg    <= asm_word;
          byte_cnt <= byte_cnt + 2'd1;
          if (last_byte) begin
            len <= asm_word;
            idx <= '0;
          end
        end
        S_DATA: if (accept && !timeout) begin
          shreg    <= asm_word;
          byte_cnt <= byte_cnt + 2'd1;
          csum     <= csum ^ rx_data_i;
          if (last_byte) begin
            ram_wdata_o <= asm_word;
            ram_addr_o  <= BaseAddr + idx;
          end
        end
        S_WRITE: idx <= idx + 30'd1;
        S_DONE:  cpu_rst_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign ram_wr_o      = (state == S_WRITE);
  assign ram_byte_en_o = {4{ram_wr_o}};
  assign busy_o        = in_rx || (state == S_WRITE);
  // Gated by rst_n so the source sees no readiness while reset is held.
  assign rx_ready_o    = rst_n && (in_rx || state == S_IDLE);
  assign cpu_rst_n_o   = cpu_rst_q;
  assign error_o       = err_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: frames built from random words,
// expected RAM writes queued by the driver and popped by a write monitor.
module tb_uart_boot_loader;
  localparam logic [29:0] BASE = 30'h3FFF_FFFF;
  localparam int unsigned MAXW = 16384;
  localparam int unsigned TO   = 40;
  localparam logic [7:0]  MAG  = 8'hB0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [29:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_wr;
  logic [3:0]  ram_be;
  logic        cpu_rst_n, busy, error;

  uart_boot_loader #(.BaseAddr(BASE), .MaxWords(MAXW), .TimeoutCycles(TO), .Magic(MAG)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .rx_ready_o(rx_ready), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
    .ram_wr_o(ram_wr), .ram_byte_en_o(ram_be), .cpu_rst_n_o(cpu_rst_n),
    .busy_o(busy), .error_o(error));

  always #5 clk = ~clk;

  typedef struct { logic [29:0] addr; logic [31:0] data; } wr_t;
  wr_t         exp_q[$];
  logic [31:0] wq[$];
  int          checks = 0, failures = 0;
  int          cyc = 0, acc_cyc = -10;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rx_valid && rx_ready) acc_cyc <= cyc + 1;
  end

  // Write monitor: every RAM write must match the oldest expectation and
  // land exactly one cycle after the byte that completed the word.
  always @(negedge clk) begin
    if (rst_n && ram_wr) begin
      if (exp_q.size() == 0) chk("unexpected_write", {2'b0, ram_addr, ram_wdata}, 64'h0);
      else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 64'(ram_addr), 64'(e.addr));
        chk("wr_data", 64'(ram_wdata), 64'(e.data));
        chk("wr_be", 64'(ram_be), 64'hF);
        chk("wr_latency", 64'(cyc), 64'(acc_cyc));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    rx_data = b; rx_valid = 1'b1;
    while (!rx_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("ready_timeout", 64'(rx_ready), 64'h1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  // Reference frame: magic, LE length, LE words from wq, XOR of data bytes.
  task automatic load(input logic [31:0] len, input bit bad);
    logic [7:0] cs;
    cs = '0;
    send_byte(MAG);
    chk("err_clear_on_magic", 64'(error), 64'h0);
    for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8]);
    if (len > MAXW) begin
      chk("oversize_err", 64'(error), 64'h1);
      chk("oversize_busy", 64'(busy), 64'h0);
      return;
    end
    for (int w = 0; w < int'(len); w++) begin
      logic [31:0] d;
      d = wq[w];
      exp_q.push_back('{addr: 30'(BASE + 30'(w)), data: d});
      for (int i = 0; i < 4; i++) begin
        cs ^= d[8*i +: 8];
        send_byte(d[8*i +: 8]);
      end
    end
    send_byte(bad ? (cs ^ 8'($urandom_range(1, 255))) : cs);
  endtask

  task automatic outcome(input string tag, input bit ok);
    repeat (3) @(negedge clk);
    chk({tag, "_err"}, 64'(error), 64'(!ok));
    chk({tag, "_cpu"}, 64'(cpu_rst_n), 64'(ok));
    chk({tag, "_busy"}, 64'(busy), 64'h0);
    chk({tag, "_ready"}, 64'(rx_ready), 64'(!ok));
    chk({tag, "_pending"}, 64'(exp_q.size()), 64'h0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, 64'(rx_ready), 64'h0);
    chk({tag, "_wr"}, 64'(ram_wr), 64'h0);
    chk({tag, "_addr"}, 64'(ram_addr), 64'h0);
    chk({tag, "_wdata"}, 64'(ram_wdata), 64'h0);
    chk({tag, "_be"}, 64'(ram_be), 64'h0);
    chk({tag, "_cpu"}, 64'(cpu_rst_n), 64'h0);
    chk({tag, "_busy"}, 64'(busy), 64'h0);
    chk({tag, "_err"}, 64'(error), 64'h0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;

    wq = '{32'h0000_0013, 32'h1234_5678};
    load(32'd2, 1'b0);
    outcome("good", 1'b1);

    do_reset();
    load(32'd2, 1'b1);
    outcome("badcs", 1'b0);
    load(32'd2, 1'b0);
    outcome("resend", 1'b1);

    do_reset();
    load(32'd0, 1'b0);
    outcome("zero", 1'b1);

    do_reset();
    load(MAXW + 1, 1'b0);
    outcome("oversize", 1'b0);

    send_byte(8'h55);
    chk("garbage_busy", 64'(busy), 64'h0);
    send_byte(8'hAA);
    chk("garbage_busy2", 64'(busy), 64'h0);
    send_byte(MAG); send_byte(8'h01); send_byte(8'h00);
    chk("partial_busy", 64'(busy), 64'h1);
    repeat (TO + 20) @(negedge clk);
    chk("timeout_err", 64'(error), 64'h1);
    chk("timeout_busy", 64'(busy), 64'h0);
    chk("timeout_ready", 64'(rx_ready), 64'h1);
    chk("timeout_cpu", 64'(cpu_rst_n), 64'h0);

    // Leave nonzero address/data on the RAM port, then abort mid-DATA.
    wq = '{32'hDEAD_BEEF, 32'hCAFE_F00D};
    load(32'd2, 1'b1);
    outcome("bad2", 1'b0);
    send_byte(MAG);
    for (int i = 0; i < 4; i++) send_byte(i == 0 ? 8'h01 : 8'h00);
    send_byte(8'hAA); send_byte(8'hBB);
    @(negedge clk); #2 rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wq = '{32'hA5A5_0001, 32'h0BAD_CAFE, 32'h7777_8888};
    load(32'd3, 1'b0);
    outcome("after_rst", 1'b1);

    // Exactly MaxWords is a legal length.
    do_reset();
    send_byte(MAG);
    for (int i = 0; i < 4; i++) send_byte(8'(MAXW >> (8 * i)));
    chk("maxw_err", 64'(error), 64'h0);
    chk("maxw_busy", 64'(busy), 64'h1);
    repeat (TO + 20) @(negedge clk);
    chk("maxw_timeout_err", 64'(error), 64'h1);

    for (int it = 0; it < 10; it++) begin
      int unsigned n;
      bit bad;
      do_reset();
      n = $urandom_range(0, 4);
      bad = ($urandom_range(0, 2) == 0);
      wq.delete();
      for (int w = 0; w < int'(n); w++) wq.push_back($urandom);
      load(32'(n), bad);
      outcome("rand", !bad);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Sits between the UART receive byte stream and the dual-port RAM data port.
- Holds the CPU core in reset while it loads a program image from the host into RAM.
- Image format: magic byte, 32-bit little-endian word count, data words little-endian, then one XOR checksum byte.
- On a good checksum it releases the CPU reset and goes permanently passive until the next reset.

Parameters:
- BaseAddr, 30'h0, word address of the first image word in RAM.
- MaxWords, 16384, largest accepted word count.
- TimeoutCycles, 1_000_000, maximum idle gap between bytes inside a frame before the frame is aborted.
- Magic, 8'hB0, start-of-frame byte.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- rx_data_i  input  8  received byte.
- rx_valid_i  input  1  rx_data_i valid.
- rx_ready_o  output  1  loader accepts a byte; a transfer occurs when valid && ready.
- ram_addr_o  output  30  RAM word address.
- ram_wdata_o  output  32  RAM write data.
- ram_wr_o  output  1  RAM write strobe, one cycle per word.
- ram_byte_en_o  output  4  byte enables: 4'hF while ram_wr_o is high, else 4'h0.
- cpu_rst_n_o  output  1  active-low CPU reset; low until the load succeeds.
- busy_o  output  1  high while a frame is in progress (LEN, DATA, WRITE, CSUM).
- error_o  output  1  sticky error flag.

Behaviour:
- Reset: applies asynchronously on rst_n low.
  - Outputs: ram_wr_o=0, ram_addr_o=0, ram_wdata_o=0, ram_byte_en_o=0, cpu_rst_n_o=0, busy_o=0, error_o=0, rx_ready_o=0.
  - State: IDLE, all counters cleared.
  - A reset mid-frame aborts the frame. RAM words already written are left in RAM.
- rx_ready_o: 1 in IDLE, LEN, DATA and CSUM; 0 in WRITE and DONE. It is 0 during reset.
- States and transitions:
  - IDLE:
    - Accepted byte == Magic: clear byte counter, checksum and error_o; go to LEN.
    - Any other byte: discard it and stay in IDLE.
  - LEN:
    - Collect 4 bytes, first byte into bits [7:0].
    - After the 4th byte:
      - count > MaxWords: set error_o, go to IDLE.
      - count == 0: go to CSUM (expected checksum 8'h00).
      - otherwise: word index = 0, go to DATA.
  - DATA:
    - Collect 4 bytes into a word, little-endian.
    - XOR every byte into the running checksum.
    - After the 4th byte, go to WRITE.
  - WRITE: lasts exactly one cycle.
    - Drive ram_wr_o=1, ram_byte_en_o=4'hF, ram_addr_o=BaseAddr+index (30-bit, wraps modulo 2^30), ram_wdata_o=assembled word.
    - Increment index. Next state is CSUM if index+1 == count, else DATA.
    - Write latency: the write occurs in the cycle after the 4th byte is accepted.
  - CSUM:
    - Accept one byte.
    - Byte == running checksum: go to DONE.
    - Mismatch: set error_o, go to IDLE.
  - DONE: terminal until reset.
    - cpu_rst_n_o=1 (registered; asserted the cycle after entering DONE).
    - rx_ready_o=0, busy_o=0.
- ram_addr_o and ram_wdata_o hold their last values outside WRITE. Only ram_wr_o qualifies them.
- Timeout:
  - In LEN, DATA and CSUM, a gap counter counts cycles with no accepted byte. Any accepted byte resets it to 0.
  - When the counter reaches TimeoutCycles: set error_o, go to IDLE.
  - Words already written stay in RAM; cpu_rst_n_o stays 0.
- error_o stays set until the next Magic byte is accepted in IDLE. It clears in the same cycle that LEN is entered.
- rx_valid_i while rx_ready_o=0: the byte is not consumed. The source must hold it.
- A Magic value inside LEN, DATA or CSUM is ordinary data; it is not a resync.
- Checksum width: 8 bits, XOR of data bytes only. Magic and length bytes are excluded.

Test Plan:
- Good load: stream B0 02 00 00 00 13 00 00 00 78 56 34 12 1B.
  - Writes 32'h00000013 to addr 0 and 32'h12345678 to addr 1, each one cycle after its 4th byte.
  - Then cpu_rst_n_o=1, rx_ready_o=0, error_o=0.
- Bad checksum: same stream but last byte 1C.
  - Both writes occur; error_o=1; state IDLE; cpu_rst_n_o stays 0.
  - Resending the good stream clears error_o and ends in DONE.
- Zero length: B0 00 00 00 00 00.
  - No ram_wr_o pulses; DONE; cpu_rst_n_o=1.
- Oversize: length MaxWords+1 (16385 = 01 40 00 00).
  - error_o=1 after the 4th length byte; no writes; back in IDLE.
- Garbage then timeout: send 55 AA (ignored, busy_o=0), then B0 01 00, then silence for TimeoutCycles (small value set for simulation).
  - error_o=1, busy_o=0, IDLE, no writes.
- Reset mid-DATA: pulse rst_n low after the 2nd data byte.
  - All outputs immediately return to reset values.
  - A following good stream loads correctly from BaseAddr.
